// File: rtl/mem_banked_pkg.sv
// mem_banked_pkg
//   Shared types and width helpers for the bank-interleaved memory.
//   mem_state_e : controller states (init clear sweep, normal run)
//   bsel_w      : bank-select width for a bank count (0 for a single bank)
//   at_least_1  : clamps a derived width so zero-width vectors never appear
package mem_banked_pkg;

  typedef enum logic {ST_INIT, ST_RUN} mem_state_e;

  function automatic int bsel_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 0;
  endfunction

  function automatic int at_least_1(input int w);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/mem_banked_if.sv
// mem_banked_if
//   Request/response bus between a requester and the banked memory.
//   read, write, addr, data_in       : request side (driven by master)
//   data_out, rd_valid, ready,
//   init_done, err                   : response side (driven by slave)
interface mem_banked_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              ready;
  logic              init_done;
  logic              err;

  modport master (
    output read, write, addr, data_in,
    input  data_out, rd_valid, ready, init_done, err
  );

  modport slave (
    input  read, write, addr, data_in,
    output data_out, rd_valid, ready, init_done, err
  );
endinterface

// File: rtl/mem_banked_bank.sv
// mem_banked_bank
//   One bank: single-port word array with write enable and registered read.
//   clk   : clock
//   we    : write wdata to row this edge
//   re    : capture mem[row] into rdata this edge
//   row   : row address
//   wdata : write data
//   rdata : registered read data (holds when re=0)
module mem_banked_bank
  import mem_banked_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ROW_W  = 4,
  localparam int ROW_AW = at_least_1(ROW_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ROW_AW-1:0] row,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ROW_W];

  // Storage is deliberately not reset; the controller's init sweep zeroes it.
  always_ff @(posedge clk) begin
    if (we) mem[row] <= wdata;
    if (re) rdata    <= mem[row];
  end

endmodule

// File: rtl/mem_banked.sv
// mem_banked
//   Bank-interleaved synchronous memory with a self-clearing init sweep,
//   registered read data with valid strobe, ready and error indication.
//   clk : clock, all state on posedge
//   rst : asynchronous active-high reset
//   bus : mem_banked_if slave (read/write/addr/data_in in;
//         data_out/rd_valid/ready/init_done/err out)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | zero one row of every bank per cycle; requests are illegal
//   ST_RUN  | normal operation; left only through rst
module mem_banked
  import mem_banked_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int NUM_BANKS = 2,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  mem_banked_if.slave bus
);

  localparam int BSEL_W  = bsel_w(NUM_BANKS);
  localparam int ROW_W   = ADDR_W - BSEL_W;
  localparam int BSEL_AW = at_least_1(BSEL_W);
  localparam int ROW_AW  = at_least_1(ROW_W);
  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'((1 << ROW_W) - 1);

  mem_state_e        state_q, state_d;
  logic [ROW_AW-1:0] clear_row;
  logic              clear_en, last_row;
  logic              ready_q, init_done_q, err_q;
  logic              acc_rd, acc_wr, illegal;
  logic [BSEL_AW-1:0] req_bank, s1_bank;
  logic [ROW_AW-1:0] req_row, bank_row;
  logic [DATA_W-1:0] bank_wdata;
  logic [DATA_W-1:0] bank_rdata [NUM_BANKS];
  logic              s1_valid, rdv1;
  logic [DATA_W-1:0] dout1;

  // Low-order interleave; degenerate widths collapse to a constant zero.
  if (BSEL_W == 0) begin : g_one_bank
    assign req_bank = '0;
  end else begin : g_bsel
    assign req_bank = bus.addr[BSEL_AW-1:0];
  end

  if (ROW_W == 0) begin : g_one_row
    assign req_row = '0;
  end else begin : g_row
    assign req_row = bus.addr[ADDR_W-1 -: ROW_AW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (last_row) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    clear_en = (state_q == ST_INIT);
    last_row = (clear_row == LAST_ROW);
  end

  // Terminal count is compared explicitly, so the counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       clear_row <= '0;
    else if (clear_en && !last_row) clear_row <= clear_row + ROW_AW'(1);
  end

  // ready/init_done come from registers loaded with the next state, so they
  // rise together with ST_RUN, the cycle after the last clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      ready_q <= (state_d == ST_RUN);
      if (state_d == ST_RUN) init_done_q <= 1'b1;
    end
  end

  assign acc_wr  = ready_q & bus.write & ~bus.read;
  assign acc_rd  = ready_q & bus.read  & ~bus.write;
  assign illegal = (bus.read & bus.write) | (~ready_q & (bus.read | bus.write));

  assign bank_row   = clear_en ? clear_row : req_row;
  assign bank_wdata = clear_en ? '0 : bus.data_in;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic sel;
    assign sel = (req_bank == BSEL_AW'(b));
    mem_banked_bank #(.DATA_W(DATA_W), .ROW_W(ROW_W)) u_bank (
      .clk   (clk),
      .we    (clear_en | (acc_wr & sel)),
      .re    (acc_rd & sel),
      .row   (bank_row),
      .wdata (bank_wdata),
      .rdata (bank_rdata[b])
    );
  end

  // s1 tracks the bank read in flight so the mux picks the bank that was
  // addressed with the request, not whatever the bus shows now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_bank  <= '0;
      rdv1     <= 1'b0;
      dout1    <= '0;
      err_q    <= 1'b0;
    end else begin
      s1_valid <= acc_rd;
      if (acc_rd) s1_bank <= req_bank;
      rdv1 <= s1_valid;
      if (s1_valid) dout1 <= bank_rdata[s1_bank];
      err_q <= illegal;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              rdv2;
    logic [DATA_W-1:0] dout2;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdv2  <= 1'b0;
        dout2 <= '0;
      end else begin
        rdv2 <= rdv1;
        if (rdv1) dout2 <= dout1;
      end
    end
    assign bus.rd_valid = rdv2;
    assign bus.data_out = dout2;
  end else begin : g_lat1
    assign bus.rd_valid = rdv1;
    assign bus.data_out = dout1;
  end

  assign bus.ready     = ready_q;
  assign bus.init_done = init_done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_banked.sv
// tb_mem_banked
//   Directed bench for mem_banked: a default instance (u0) and a
//   RD_LAT=2 / 4-bank / 64-word instance (u1) share clock and reset.
//   Expected read data and arrival cycle are queued at request time and
//   popped when rd_valid is seen.
module tb_mem_banked;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   passed = 0;
  int   failed = 0;
  int   total = 0;
  exp_t q0[$];
  exp_t q1[$];

  mem_banked_if #(.DATA_W(8), .ADDR_W(5)) b0 ();
  mem_banked_if #(.DATA_W(8), .ADDR_W(6)) b1 ();

  mem_banked #(.DATA_W(8), .ADDR_W(5), .NUM_BANKS(2), .RD_LAT(1)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  mem_banked #(.DATA_W(8), .ADDR_W(6), .NUM_BANKS(4), .RD_LAT(2)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors; an rd_valid with nothing pending fails on the cycle.
  always @(negedge clk) begin
    if (b0.rd_valid === 1'b1) begin
      exp_t e;
      e.data = 8'h00;
      e.due  = -1;
      if (q0.size() > 0) e = q0.pop_front();
      chk("u0_rd_cycle", cyc, e.due);
      chk("u0_rd_data", b0.data_out, e.data);
    end
  end

  always @(negedge clk) begin
    if (b1.rd_valid === 1'b1) begin
      exp_t e;
      e.data = 8'h00;
      e.due  = -1;
      if (q1.size() > 0) e = q1.pop_front();
      chk("u1_rd_cycle", cyc, e.due);
      chk("u1_rd_data", b1.data_out, e.data);
    end
  end

  // All drive tasks are entered just after a negedge and return one negedge later.
  task automatic rd0(input logic [4:0] a, input logic [7:0] d);
    b0.read = 1'b1; b0.write = 1'b0; b0.addr = a;
    q0.push_back('{data: d, due: cyc + 2});
    @(negedge clk);
    b0.read = 1'b0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [7:0] d);
    b0.read = 1'b0; b0.write = 1'b1; b0.addr = a; b0.data_in = d;
    @(negedge clk);
    b0.write = 1'b0;
  endtask

  task automatic rd1(input logic [5:0] a, input logic [7:0] d);
    b1.read = 1'b1; b1.write = 1'b0; b1.addr = a;
    q1.push_back('{data: d, due: cyc + 3});
    @(negedge clk);
    b1.read = 1'b0;
  endtask

  task automatic wr1(input logic [5:0] a, input logic [7:0] d);
    b1.read = 1'b0; b1.write = 1'b1; b1.addr = a; b1.data_in = d;
    @(negedge clk);
    b1.write = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (5) @(negedge clk);
    chk({tag, "_q0_empty"}, q0.size(), 0);
    chk({tag, "_q1_empty"}, q1.size(), 0);
  endtask

  task automatic wait_ready(output int n0, output int n1);
    int n;
    n  = 0;
    n0 = -1;
    n1 = -1;
    while ((n0 < 0 || n1 < 0) && n < 100) begin
      @(negedge clk);
      n++;
      if (b0.ready === 1'b1 && n0 < 0) n0 = n;
      if (b1.ready === 1'b1 && n1 < 0) n1 = n;
    end
  endtask

  initial begin
    int n0, n1;
    b0.read = 1'b0; b0.write = 1'b0; b0.addr = '0; b0.data_in = '0;
    b1.read = 1'b0; b1.write = 1'b0; b1.addr = '0; b1.data_in = '0;
    repeat (3) @(negedge clk);

    chk("rst_ready",     b0.ready, 0);
    chk("rst_init_done", b0.init_done, 0);
    chk("rst_data_out",  b0.data_out, 8'h00);
    chk("rst_rd_valid",  b0.rd_valid, 0);
    chk("rst_err",       b0.err, 0);
    chk("rst_u1_ready",  b1.ready, 0);

    // 1: init sweep length and all-zero contents
    rst = 1'b0;
    wait_ready(n0, n1);
    chk("init_cycles_u0", n0, 16);
    chk("init_cycles_u1", n1, 16);
    chk("init_done_u0", b0.init_done, 1);
    chk("init_done_u1", b1.init_done, 1);
    for (int a = 0; a < 32; a++) rd0(5'(a), 8'h00);
    drain("t1");

    // 2: write then read next cycle
    wr0(5'd3, 8'hA5);
    rd0(5'd3, 8'hA5);
    drain("t2");

    // 3: two banks, back-to-back reads in order
    wr0(5'd4, 8'h11);
    wr0(5'd5, 8'h22);
    rd0(5'd4, 8'h11);
    rd0(5'd5, 8'h22);
    rd0(5'd3, 8'hA5);
    drain("t3");

    // 4: simultaneous read and write is rejected
    wr0(5'd7, 8'h77);
    b0.read = 1'b1; b0.write = 1'b1; b0.addr = 5'd7; b0.data_in = 8'hFF;
    @(negedge clk);
    b0.read = 1'b0; b0.write = 1'b0;
    chk("rw_err_pulse", b0.err, 1);
    @(negedge clk);
    chk("rw_err_clear", b0.err, 0);
    rd0(5'd7, 8'h77);
    drain("t4");

    // 5: RD_LAT=2, 4 banks, top address
    wr1(6'd63, 8'h3C);
    wr1(6'd62, 8'hC3);
    rd1(6'd63, 8'h3C);
    rd1(6'd62, 8'hC3);
    rd1(6'd61, 8'h00);
    drain("t5");

    // 6: reset with a read in flight, then a request during init
    b0.read = 1'b1; b0.addr = 5'd3;
    @(negedge clk);
    b0.read = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_data_out", b0.data_out, 8'h00);
    chk("midrst_ready", b0.ready, 0);
    chk("midrst_init_done", b0.init_done, 0);
    @(negedge clk);
    chk("midrst_no_rdv", b0.rd_valid, 0);
    rst = 1'b0;
    b0.read = 1'b1; b0.addr = 5'd3;
    @(negedge clk);
    b0.read = 1'b0;
    chk("init_req_err", b0.err, 1);
    chk("init_req_ready", b0.ready, 0);
    wait_ready(n0, n1);
    chk("reinit_cycles_u0", n0, 15);
    rd0(5'd3, 8'h00);
    rd0(5'd4, 8'h00);
    drain("t6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
